board_clock_reset_unit: RTL and testbench

Board-support front end that sits between the FPGA board pins and the `rvsteel` instance in every board top. It replaces ad-hoc per-board logic with one parametrised block:
- a divided system clock with a matching clock-enable pulse
- an N-channel synchronising button debouncer with edge pulses
- a stretched, clock-aligned core reset, optionally requestable from a debounced button

---
 rtl/board_clock_reset_unit.sv | 173 +++++++++++++++++
 tb/tb_board_clock_reset_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_clock_reset_unit.sv
// board_clock_reset_unit
//
// Board-support front end placed between the FPGA pins and the rvsteel core.
// It provides a divided system clock with a matching clock-enable pulse,
// debounced button channels with edge pulses, and a stretched core reset
// that is released in step with the divided clock.
//
// Ports:
//   clock             in   board clock, the only clock in the block
//   reset             in   asynchronous active-low reset
//   buttons           in   raw active-high button levels, asynchronous
//   clock_div         out  divided clock, 50% duty, period CLOCK_DIVIDER
//   clock_enable      out  one-cycle pulse in the cycle clock_div rises
//   buttons_debounced out  debounced button levels
//   buttons_rise      out  one-cycle pulse on a debounced 0->1 change
//   buttons_fall      out  one-cycle pulse on a debounced 1->0 change
//   core_reset        out  active-high reset for the core
//
// Core reset FSM states:
//   state      | meaning
//   HOLD       | core_reset high, counting clean cycles after release/request
//   WAIT_ALIGN | hold time done, waiting for the next clock_div rising edge
//   RUN        | core_reset low, watching for a button reset request

module board_clock_reset_unit #(
  parameter int CLOCK_DIVIDER     = 2,
  parameter int NUM_BUTTONS       = 1,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int RESET_FROM_BUTTON = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   clock_div,
  output logic                   clock_enable,
  output logic [NUM_BUTTONS-1:0] buttons_debounced,
  output logic [NUM_BUTTONS-1:0] buttons_rise,
  output logic [NUM_BUTTONS-1:0] buttons_fall,
  output logic                   core_reset
);

  localparam int HALF   = CLOCK_DIVIDER / 2;
  localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             div_rise;

  assign div_wrap = (div_cnt == DIV_LAST);
  // True on the edge that will take clock_div from 0 to 1.
  assign div_rise = div_wrap & ~clock_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt      <= '0;
      clock_div    <= 1'b0;
      clock_enable <= 1'b0;
    end else begin
      clock_enable <= div_rise;
      if (div_wrap) begin
        div_cnt   <= '0;
        clock_div <= ~clock_div;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- buttons
  logic [NUM_BUTTONS-1:0] btn_meta;
  logic [NUM_BUTTONS-1:0] btn_sync;
  logic [DEB_W-1:0]       deb_cnt [NUM_BUTTONS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta          <= '0;
      btn_sync          <= '0;
      buttons_debounced <= '0;
      buttons_rise      <= '0;
      buttons_fall      <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      btn_meta     <= buttons;
      btn_sync     <= btn_meta;
      buttons_rise <= '0;
      buttons_fall <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (btn_sync[i] != buttons_debounced[i]) begin
          // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample.
          if (deb_cnt[i] == DEB_LAST) begin
            deb_cnt[i]           <= '0;
            buttons_debounced[i] <= btn_sync[i];
            buttons_rise[i]      <= btn_sync[i];
            buttons_fall[i]      <= ~btn_sync[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // ------------------------------------------------------------- core reset
  typedef enum logic [1:0] {HOLD, WAIT_ALIGN, RUN} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic [HOLD_W-1:0] hold_cnt;
  logic              btn_req;

  assign btn_req = (RESET_FROM_BUTTON != 0) ? buttons_debounced[0] : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= HOLD;
      rst_sync   <= 2'b00;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      case (state)
        HOLD: begin
          core_reset <= 1'b1;
          if (btn_req) begin
            hold_cnt <= '0;
          end else if (rst_sync[1]) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= WAIT_ALIGN;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        WAIT_ALIGN: begin
          // A request wins over alignment so a press never slips through.
          if (btn_req) begin
            hold_cnt <= '0;
            state    <= HOLD;
          end else if (div_rise) begin
            core_reset <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (btn_req) begin
            core_reset <= 1'b1;
            hold_cnt   <= '0;
            state      <= HOLD;
          end
        end
        default: begin
          core_reset <= 1'b1;
          hold_cnt   <= '0;
          state      <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_clock_reset_unit.sv
module tb_board_clock_reset_unit;

  localparam int CD   = 4;
  localparam int NB   = 2;
  localparam int DEB  = 8;
  localparam int RHC  = 16;
  localparam int MAXE = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] buttons = '0;

  logic          clock_div, clock_enable, core_reset;
  logic [NB-1:0] buttons_debounced, buttons_rise, buttons_fall;
  logic          nb_clock_div, nb_clock_enable, nb_core_reset;
  logic [NB-1:0] nb_debounced, nb_rise, nb_fall;

  int checks = 0;
  int failures = 0;

  board_clock_reset_unit #(
    .CLOCK_DIVIDER(CD), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(RHC), .RESET_FROM_BUTTON(1)
  ) u_dut (
    .clock(clock), .reset(reset), .buttons(buttons),
    .clock_div(clock_div), .clock_enable(clock_enable),
    .buttons_debounced(buttons_debounced), .buttons_rise(buttons_rise),
    .buttons_fall(buttons_fall), .core_reset(core_reset)
  );

  board_clock_reset_unit #(
    .CLOCK_DIVIDER(CD), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(RHC), .RESET_FROM_BUTTON(0)
  ) u_dut_nb (
    .clock(clock), .reset(reset), .buttons(buttons),
    .clock_div(nb_clock_div), .clock_enable(nb_clock_enable),
    .buttons_debounced(nb_debounced), .buttons_rise(nb_rise),
    .buttons_fall(nb_fall), .core_reset(nb_core_reset)
  );

  always #5 clock = ~clock;

  // Reference model: n counts clock edges since reset was released.
  // Divider outputs follow from n directly; a button flips once the last DEB
  // synchronised samples (raw delayed two edges) all differ from the current
  // level and at least DEB edges have passed since its previous flip. The core
  // reset falls on the first clock_div rising edge that is more than RHC edges
  // past the later of reset-sync completion (edge 2) and the last request.
  int            n;
  int            last_block;
  int            last_flip [NB];
  logic [NB-1:0] raw_hist [MAXE];
  logic [NB-1:0] m_deb, m_rise, m_fall;
  logic          m_core, m_core_nb, m_div, m_ce, m_req, m_stable, m_s;
  int            m_j;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      n = 0;
      last_block = 2;
      m_deb = '0;
      m_rise = '0;
      m_fall = '0;
      m_core = 1'b1;
      m_core_nb = 1'b1;
      m_div = 1'b0;
      m_ce = 1'b0;
      for (int ch = 0; ch < NB; ch++) last_flip[ch] = 0;
    end else begin
      n = n + 1;
      raw_hist[n % MAXE] = buttons;
      m_div = ((n / (CD / 2)) % 2) == 1;
      m_ce = (n % CD) == (CD / 2);
      m_req = m_deb[0];
      if (m_req) last_block = n;
      if (m_core && m_ce && n > last_block + RHC) m_core = 1'b0;
      if (m_req) m_core = 1'b1;
      if (m_core_nb && m_ce && n > 2 + RHC) m_core_nb = 1'b0;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < NB; ch++) begin
        m_stable = (n - last_flip[ch]) >= DEB;
        for (int k = 0; k < DEB; k++) begin
          m_j = n - k - 2;
          m_s = (m_j >= 1) ? raw_hist[m_j % MAXE][ch] : 1'b0;
          if (m_s == m_deb[ch]) m_stable = 1'b0;
        end
        if (m_stable) begin
          m_deb[ch] = ~m_deb[ch];
          last_flip[ch] = n;
          if (m_deb[ch]) m_rise[ch] = 1'b1;
          else m_fall[ch] = 1'b1;
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    buttons = 2'($urandom);
    repeat (4) @(negedge clock);
    checks++; if (clock_div !== 1'b0) begin failures++; $display("FAIL reset_clock_div: got %b expected 0", clock_div); end
    checks++; if (clock_enable !== 1'b0) begin failures++; $display("FAIL reset_clock_enable: got %b expected 0", clock_enable); end
    checks++; if (buttons_debounced !== 2'b00) begin failures++; $display("FAIL reset_debounced: got %b expected 00", buttons_debounced); end
    checks++; if ((buttons_rise | buttons_fall) !== 2'b00) begin failures++; $display("FAIL reset_edges: got rise %b fall %b expected 00", buttons_rise, buttons_fall); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if (nb_core_reset !== 1'b1 || nb_clock_div !== 1'b0) begin failures++; $display("FAIL reset_nb: got core %b div %b expected 1 0", nb_core_reset, nb_clock_div); end
    buttons = '0;
  endtask

  task automatic test_divider_release;
    int fall_edge = -1;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      checks++; if (clock_div !== m_div) begin failures++; $display("FAIL div_clock_div edge %0d: got %b expected %b", k, clock_div, m_div); end
      checks++; if (clock_enable !== m_ce) begin failures++; $display("FAIL div_clock_enable edge %0d: got %b expected %b", k, clock_enable, m_ce); end
      checks++; if (core_reset !== m_core) begin failures++; $display("FAIL release_core_reset edge %0d: got %b expected %b", k, core_reset, m_core); end
      if (fall_edge < 0 && core_reset === 1'b0) begin
        fall_edge = k;
        checks++; if (clock_enable !== 1'b1) begin failures++; $display("FAIL release_on_enable: got enable %b expected 1", clock_enable); end
      end
    end
    // clock_div rises on edges 2,6,10,..; first one beyond edge 2+RHC=18 is 22.
    checks++; if (fall_edge != 22) begin failures++; $display("FAIL release_edge: got %0d expected 22", fall_edge); end
  endtask

  task automatic test_clean_press;
    @(negedge clock);
    buttons[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      checks++; if (buttons_debounced[1] !== (k >= DEB + 2)) begin failures++; $display("FAIL press_level edge %0d: got %b expected %b", k, buttons_debounced[1], k >= DEB + 2); end
      checks++; if (buttons_rise[1] !== (k == DEB + 2)) begin failures++; $display("FAIL press_rise edge %0d: got %b expected %b", k, buttons_rise[1], k == DEB + 2); end
      checks++; if (buttons_debounced[0] !== 1'b0 || buttons_rise[0] !== 1'b0 || core_reset !== 1'b0) begin failures++; $display("FAIL press_ch0 edge %0d: got deb0 %b rise0 %b core %b expected 0 0 0", k, buttons_debounced[0], buttons_rise[0], core_reset); end
    end
    buttons[1] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      checks++; if (buttons_debounced[1] !== (k < DEB + 2)) begin failures++; $display("FAIL release_level edge %0d: got %b expected %b", k, buttons_debounced[1], k < DEB + 2); end
      checks++; if (buttons_fall[1] !== (k == DEB + 2)) begin failures++; $display("FAIL release_fall edge %0d: got %b expected %b", k, buttons_fall[1], k == DEB + 2); end
    end
  endtask

  task automatic test_bounce;
    int rises = 0;
    @(negedge clock);
    buttons[1] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clock);
      if (buttons_rise[1] === 1'b1) rises++;
      checks++; if (buttons_debounced[1] !== (t >= 19)) begin failures++; $display("FAIL bounce_level t=%0d: got %b expected %b", t, buttons_debounced[1], t >= 19); end
      if (t == 7) buttons[1] = 1'b0;
      if (t == 9) buttons[1] = 1'b1;
    end
    checks++; if (rises != 1) begin failures++; $display("FAIL bounce_rise_count: got %0d expected 1", rises); end
    buttons[1] = 1'b0;
    repeat (DEB + 4) @(negedge clock);
  endtask

  task automatic test_button_reset;
    int fall_k = -1;
    @(negedge clock);
    buttons[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checks++; if (buttons_debounced[0] !== (k >= DEB + 2)) begin failures++; $display("FAIL req_level edge %0d: got %b expected %b", k, buttons_debounced[0], k >= DEB + 2); end
      checks++; if (core_reset !== (k >= DEB + 3)) begin failures++; $display("FAIL req_core_reset edge %0d: got %b expected %b", k, core_reset, k >= DEB + 3); end
    end
    buttons[0] = 1'b0;
    for (int k = 1; k <= 60 && fall_k < 0; k++) begin
      @(negedge clock);
      checks++; if (core_reset !== m_core) begin failures++; $display("FAIL req_release edge %0d: got %b expected %b", k, core_reset, m_core); end
      if (core_reset === 1'b0) begin
        fall_k = k;
        checks++; if (clock_enable !== 1'b1) begin failures++; $display("FAIL req_release_enable: got %b expected 1", clock_enable); end
      end
    end
    // Debounced release lands at edge DEB+2; hold must run RHC edges beyond it.
    checks++; if (fall_k < 0 || fall_k - (DEB + 2) <= RHC || fall_k - (DEB + 2) > RHC + CD) begin failures++; $display("FAIL req_release_delay: got fall edge %0d expected in %0d..%0d", fall_k, DEB + 3 + RHC, DEB + 2 + RHC + CD); end
  endtask

  task automatic test_ordinary_button;
    @(negedge clock);
    buttons[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      checks++; if (nb_debounced[0] !== (k >= DEB + 2)) begin failures++; $display("FAIL nb_level edge %0d: got %b expected %b", k, nb_debounced[0], k >= DEB + 2); end
      checks++; if (nb_rise[0] !== (k == DEB + 2)) begin failures++; $display("FAIL nb_rise edge %0d: got %b expected %b", k, nb_rise[0], k == DEB + 2); end
      checks++; if (nb_core_reset !== 1'b0) begin failures++; $display("FAIL nb_core_reset edge %0d: got %b expected 0", k, nb_core_reset); end
    end
    buttons[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      checks++; if (nb_core_reset !== 1'b0 || nb_fall[0] !== (k == DEB + 2)) begin failures++; $display("FAIL nb_release edge %0d: got core %b fall %b expected 0 %b", k, nb_core_reset, nb_fall[0], k == DEB + 2); end
    end
  endtask

  task automatic test_async_mid;
    int waited = 0;
    while (core_reset !== 1'b0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL mid_pre_run: got %b expected 0", core_reset); end
    buttons[1] = 1'b1;
    repeat (DEB + 4) @(negedge clock);
    buttons[1] = 1'b0;
    repeat (7) @(negedge clock);
    checks++; if (buttons_debounced[1] !== 1'b1) begin failures++; $display("FAIL mid_pre_level: got %b expected 1", buttons_debounced[1]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (buttons_debounced !== 2'b00 || clock_div !== 1'b0 || clock_enable !== 1'b0) begin failures++; $display("FAIL mid_async_outputs: got deb %b div %b en %b expected 00 0 0", buttons_debounced, clock_div, clock_enable); end
    checks++; if (core_reset !== 1'b1 || nb_core_reset !== 1'b1) begin failures++; $display("FAIL mid_async_core: got %b %b expected 1 1", core_reset, nb_core_reset); end
    buttons[1] = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checks++; if (buttons_debounced[1] !== (k >= DEB + 2)) begin failures++; $display("FAIL mid_restart_level edge %0d: got %b expected %b", k, buttons_debounced[1], k >= DEB + 2); end
      checks++; if (clock_div !== m_div) begin failures++; $display("FAIL mid_restart_div edge %0d: got %b expected %b", k, clock_div, m_div); end
    end
    buttons[1] = 1'b0;
  endtask

  task automatic test_random;
    int seg = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clock);
      checks++; if (clock_div !== m_div || clock_enable !== m_ce) begin failures++; $display("FAIL rand_divider cycle %0d: got %b%b expected %b%b", c, clock_div, clock_enable, m_div, m_ce); end
      checks++; if (buttons_debounced !== m_deb || nb_debounced !== m_deb) begin failures++; $display("FAIL rand_debounced cycle %0d: got %b/%b expected %b", c, buttons_debounced, nb_debounced, m_deb); end
      checks++; if (buttons_rise !== m_rise || buttons_fall !== m_fall) begin failures++; $display("FAIL rand_edges cycle %0d: got rise %b fall %b expected %b %b", c, buttons_rise, buttons_fall, m_rise, m_fall); end
      checks++; if (core_reset !== m_core || nb_core_reset !== m_core_nb) begin failures++; $display("FAIL rand_core_reset cycle %0d: got %b/%b expected %b/%b", c, core_reset, nb_core_reset, m_core, m_core_nb); end
      if (seg == 0) begin
        buttons = 2'($urandom);
        seg = $urandom_range(1, 3 * DEB);
      end else begin
        seg--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider_release();
    test_clean_press();
    test_bounce();
    test_button_reset();
    test_ordinary_button();
    test_async_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
